// File: rtl/alu_seq_exec_if.sv
// Start/Busy/Done bundle between the control FSM and the sequential ALU.
// Operands go in with Start; Result/Zero/IllegalOp come back with Done.
interface alu_seq_exec_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) ();
  logic               Start;
  logic [1:0]         ALUOp;
  logic [5:0]         Funct;
  logic [SHAMT_W-1:0] Shamt;
  logic [WIDTH-1:0]   SrcA;
  logic [WIDTH-1:0]   SrcB;
  logic               Busy;
  logic               Done;
  logic [WIDTH-1:0]   Result;
  logic               Zero;
  logic               IllegalOp;

  modport master (
    output Start, ALUOp, Funct, Shamt, SrcA, SrcB,
    input  Busy, Done, Result, Zero, IllegalOp
  );

  modport slave (
    input  Start, ALUOp, Funct, Shamt, SrcA, SrcB,
    output Busy, Done, Result, Zero, IllegalOp
  );
endinterface

// File: rtl/alu_seq_exec.sv
// MIPS ALU-control decode plus execute: one-cycle arith/logic,
// iterative shifts at SHIFT_STEP bits per cycle, registered result.
module alu_seq_exec #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_W    = 5,
  parameter int SHIFT_STEP = 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  alu_seq_exec_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               left_q, left_d;
  logic               arith_q, arith_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d;
  logic               ill_q, ill_d;
  logic               done_q, done_d;

  logic               is_shift;
  logic               shl;
  logic               sar;
  logic               ill;
  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0]   alu_r;
  logic               go_shift;
  logic [SHAMT_W-1:0] s;
  logic [WIDTH-1:0]   shifted;

  // Shift decodes yield SrcB as their result so amount 0 is a plain op
  always_comb begin
    is_shift = 1'b0;
    shl      = 1'b0;
    sar      = 1'b0;
    ill      = 1'b0;
    amt      = bus.Shamt;
    alu_r    = '0;
    unique case (bus.ALUOp)
      2'b00: alu_r = bus.SrcA + bus.SrcB;
      2'b01: alu_r = bus.SrcA - bus.SrcB;
      2'b10: begin
        unique case (bus.Funct)
          6'b100000: alu_r = bus.SrcA + bus.SrcB;
          6'b100010: alu_r = bus.SrcA - bus.SrcB;
          6'b100100: alu_r = bus.SrcA & bus.SrcB;
          6'b100101: alu_r = bus.SrcA | bus.SrcB;
          6'b101010: alu_r = {{(WIDTH-1){1'b0}},
            $signed(bus.SrcA) < $signed(bus.SrcB)};
          6'b000000: begin
            is_shift = 1'b1;
            shl      = 1'b1;
            alu_r    = bus.SrcB;
          end
          6'b000010: begin
            is_shift = 1'b1;
            alu_r    = bus.SrcB;
          end
          6'b000011: begin
            is_shift = 1'b1;
            sar      = 1'b1;
            alu_r    = bus.SrcB;
          end
          6'b000100: begin
            is_shift = 1'b1;
            shl      = 1'b1;
            amt      = bus.SrcA[SHAMT_W-1:0];
            alu_r    = bus.SrcB;
          end
          6'b000110: begin
            is_shift = 1'b1;
            amt      = bus.SrcA[SHAMT_W-1:0];
            alu_r    = bus.SrcB;
          end
          6'b000111: begin
            is_shift = 1'b1;
            sar      = 1'b1;
            amt      = bus.SrcA[SHAMT_W-1:0];
            alu_r    = bus.SrcB;
          end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
  end

  assign go_shift = is_shift && (amt != '0);

  always_comb begin
    s = (rem_q < STEP) ? rem_q : STEP;
    if (left_q)
      shifted = work_q << s;
    else if (arith_q)
      shifted = $signed(work_q) >>> s;
    else
      shifted = work_q >> s;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ill_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      left_q  <= left_d;
      arith_q <= arith_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.Start && go_shift) state_d = SHIFT;
      SHIFT: if (rem_q == s) state_d = IDLE;
    endcase
  end

  always_comb begin
    work_d  = work_q;
    rem_d   = rem_q;
    left_d  = left_q;
    arith_d = arith_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (go_shift) begin
            work_d  = bus.SrcB;
            rem_d   = amt;
            left_d  = shl;
            arith_d = sar;
          end else begin
            done_d = 1'b1;
            res_d  = alu_r;
            zero_d = (alu_r == '0);
            ill_d  = ill;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - s;
        if (rem_q == s) begin
          done_d = 1'b1;
          res_d  = shifted;
          zero_d = (shifted == '0);
          ill_d  = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    bus.Busy      = (state_q == SHIFT);
    bus.Done      = done_q;
    bus.Result    = res_q;
    bus.Zero      = zero_q;
    bus.IllegalOp = ill_q;
  end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Parametrised successor to the combinational ALU-control decode for the multi-cycle MIPS datapath.
- Decodes ALUOp/Funct and also executes the operation: arithmetic and logic ops take one cycle; shifts run iteratively at SHIFT_STEP bits per cycle.
- Uses a Start/Busy/Done handshake with the control FSM, registers its result, and flags illegal operations explicitly.

Parameters:
- WIDTH, 32, datapath width in bits (≥8, power of 2).
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).
- SHIFT_STEP, 1, maximum bits shifted per cycle (1..WIDTH/2, power of 2).

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  request; sampled only in IDLE.
- ALUOp  in  2  00=ADD, 01=SUB, 10=R-type (use Funct), 11=illegal.
- Funct  in  6  R-type function field.
- Shamt  in  SHAMT_W  immediate shift amount.
- SrcA  in  WIDTH  operand A; low SHAMT_W bits are the variable shift amount.
- SrcB  in  WIDTH  operand B; the value being shifted.
- Busy  out  1  high while in SHIFT.
- Done  out  1  one-cycle completion pulse.
- Result  out  WIDTH  registered result; held until the next completion.
- Zero  out  1  (Result==0), registered together with Result.
- IllegalOp  out  1  registered with Done; high if the last op was undecodable.

Behaviour:
- Reset (async, Reset_n=0): state=IDLE; Busy=0, Done=0, Result=0, Zero=1, IllegalOp=0. Any in-flight shift is discarded. First legal Start is accepted on the first edge after release.
- Decode for ALUOp=10:
  - Funct 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 101010 SLT (signed).
  - Funct 000000 SLL, 000010 SRL, 000011 SRA: amount = Shamt.
  - Funct 000100 SLLV, 000110 SRLV, 000111 SRAV: amount = SrcA[SHAMT_W-1:0].
  - Any other Funct is illegal. ALUOp=11 is illegal.
- Arithmetic: ADD/SUB wrap mod 2^WIDTH, no overflow flag. SLT gives 1 or 0, zero-extended. SRA/SRAV fill with the latched SrcB[WIDTH-1].
- FSM states: IDLE, SHIFT.
  - IDLE, Start=0: stay; Done=0.
  - IDLE, Start=1, non-shift or illegal op: at that edge write Result/Zero/IllegalOp, pulse Done=1, stay IDLE. Latency 1.
  - IllegalOp: Result=0, Zero=1, IllegalOp=1. The previous Result is NOT held.
  - IDLE, Start=1, shift with amount 0: treated as a single-cycle op, Result=SrcB.
  - IDLE, Start=1, shift with amount N>0: latch SrcB, N, direction and arithmetic flag; go to SHIFT; Busy=1 from the next cycle.
  - SHIFT, each edge: shift the working register by s=min(SHIFT_STEP, remaining), remaining -= s.
  - SHIFT, when remaining reaches 0: at that edge write Result/Zero, IllegalOp=0, Done=1, return to IDLE, Busy=0.
- Shift latency: 1 + ceil(N/SHIFT_STEP) edges from the Start edge to Done visible.
- Done is high for exactly one cycle per accepted Start.
- Start while Busy is ignored: no queueing, no error.
- Start in the cycle Done is high is accepted (state is IDLE).
- Operand and control inputs are don't-care after the Start edge; all values are latched.
- Result, Zero and IllegalOp change only on a Done edge or on reset.

Test Plan:
- ADD: ALUOp=00, SrcA=5, SrcB=7, Start 1 cycle -> Done after 1 edge, Result=12, Zero=0, Busy never high.
- SUB and SLT: ALUOp=01, SrcA=SrcB=0x1234 -> Result=0, Zero=1. Then SLT with SrcA=0xFFFFFFFF, SrcB=1 -> Result=1.
- Shifts, SHIFT_STEP=1:
  - SLL Shamt=5, SrcB=1 -> Busy 5 cycles, Done on edge 6, Result=0x20.
  - SRAV SrcA=4, SrcB=0x80000000 -> Result=0xF8000000 after 5 edges.
- SHIFT_STEP=4, SRL Shamt=31, SrcB=0xFFFFFFFF -> 8 shift cycles (7×4 + 1×3), Done on edge 9, Result=1.
- Start pulsed mid-shift with an ADD -> ignored, one Done only. Back-to-back Start on the Done cycle -> accepted, second Done 1 edge later.
- ALUOp=10, Funct=0x3F -> Done after 1 edge, IllegalOp=1, Result=0. Reset_n low mid-SHIFT -> immediate Busy=0, Done=0, Result=0, and no Done after release.
